// File: rtl/track_buffer_dirty_dp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : track_buffer_dirty_dp_if                                        |
// | Desc     : Port bundle for the dual-port track buffer and its flush logic. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface track_buffer_dirty_dp_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int BLK_W  = 8
);
  localparam int NBLK_W = ADDR_W - BLK_W;

  logic              a_ce;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic [DATA_W-1:0] a_dout;
  logic              b_ce;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic [DATA_W-1:0] b_dout;
  logic              clear_dirty;
  logic              flush_start;
  logic              wb_req;
  logic [NBLK_W-1:0] wb_blk;
  logic              wb_ack;
  logic              busy;
  logic              flush_done;
  logic              dirty_any;

  modport slave (
    input  a_ce, a_we, a_addr, a_din, b_ce, b_we, b_addr, b_din,
           clear_dirty, flush_start, wb_ack,
    output a_dout, b_dout, wb_req, wb_blk, busy, flush_done, dirty_any
  );

  modport master (
    output a_ce, a_we, a_addr, a_din, b_ce, b_we, b_addr, b_din,
           clear_dirty, flush_start, wb_ack,
    input  a_dout, b_dout, wb_req, wb_blk, busy, flush_done, dirty_any
  );
endinterface
`default_nettype wire

// File: rtl/track_buffer_dirty_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : track_buffer_dirty_dp                                           |
// | Desc     : True-dual-port track buffer with per-block dirty bits and a     |
// |            flush scanner feeding an SD write-back engine (req/ack).        |
// |            Define TRACK_BUFFER_OREG_EN for an extra, resettable output reg.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module track_buffer_dirty_dp #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int BLK_W  = 8
) (
  input wire logic                 clk,
  input wire logic                 reset,
  track_buffer_dirty_dp_if.slave   bus
);
  localparam int                NBLK_W   = ADDR_W - BLK_W;
  localparam int                NBLK     = 2 ** NBLK_W;
  localparam logic [NBLK_W-1:0] LAST_BLK = NBLK_W'(NBLK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [DATA_W-1:0] a_rd_d, a_rd_q;
  logic [DATA_W-1:0] b_rd_d, b_rd_q;
  logic [NBLK-1:0]   dirty_d, dirty_q;
  logic              dirty_any_d, dirty_any_q;
  state_t            state_d, state_q;
  logic [NBLK_W-1:0] idx_d, idx_q;

  logic              a_wr, b_wr, ack_fire;
  logic [NBLK_W-1:0] b_blk;

  assign a_wr     = bus.a_ce && bus.a_we;
  assign b_wr     = bus.b_ce && bus.b_we;
  assign b_blk    = bus.b_addr[ADDR_W-1:BLK_W];
  assign ack_fire = (state_q == S_REQ) && bus.wb_ack;

  // Port B write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (a_wr) mem[bus.a_addr] <= bus.a_din;
    if (b_wr) mem[bus.b_addr] <= bus.b_din;
  end

  // Reads see pre-write contents; own-port writes pass din straight through.
  always_comb begin
    a_rd_d = a_rd_q;
    b_rd_d = b_rd_q;
    if (bus.a_ce) a_rd_d = bus.a_we ? bus.a_din : mem[bus.a_addr];
    if (bus.b_ce) b_rd_d = bus.b_we ? bus.b_din : mem[bus.b_addr];
  end

  always_ff @(posedge clk) begin
    a_rd_q <= a_rd_d;
    b_rd_q <= b_rd_d;
  end

`ifdef TRACK_BUFFER_OREG_EN
  logic [DATA_W-1:0] a_oreg_d, a_oreg_q;
  logic [DATA_W-1:0] b_oreg_d, b_oreg_q;

  always_comb begin
    a_oreg_d = a_rd_q;
    b_oreg_d = b_rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_oreg_q <= '0;
      b_oreg_q <= '0;
    end else begin
      a_oreg_q <= a_oreg_d;
      b_oreg_q <= b_oreg_d;
    end
  end

  assign bus.a_dout = a_oreg_q;
  assign bus.b_dout = b_oreg_q;
`else
  assign bus.a_dout = a_rd_q;
  assign bus.b_dout = b_rd_q;
`endif

  // Later assignments take priority: B-write set > clear/ack > hold.
  always_comb begin
    dirty_d = dirty_q;
    if (bus.clear_dirty) dirty_d = '0;
    if (ack_fire)        dirty_d[idx_q] = 1'b0;
    if (b_wr)            dirty_d[b_blk] = 1'b1;
    dirty_any_d = |dirty_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.flush_start) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (dirty_q[idx_q])        state_d = S_REQ;
        else if (idx_q == LAST_BLK) state_d = S_DONE;
        else                        idx_d   = idx_q + NBLK_W'(1);
      end
      S_REQ: begin
        if (bus.wb_ack) begin
          if (idx_q == LAST_BLK) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + NBLK_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dirty_q     <= '0;
      dirty_any_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dirty_q     <= dirty_d;
      dirty_any_q <= dirty_any_d;
    end
  end

  assign bus.wb_req     = (state_q == S_REQ);
  assign bus.wb_blk     = idx_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.flush_done = (state_q == S_DONE);
  assign bus.dirty_any  = dirty_any_q;

endmodule
`default_nettype wire
